// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results take priority over an in-order
// long-latency FIFO, with a starvation limit and pending-write lookups for hazard detection.
module wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    output logic        alu_stall,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  pend_raddr1,
    output logic        pend_hit1,
    input  logic [4:0]  pend_raddr2,
    output logic        pend_hit2
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    logic [4:0]      fifo_addr_q [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [StW-1:0]  starve_cnt_q;

    logic fifo_nonempty, force_drain, grant_alu, grant_fifo, push;

    assign fifo_nonempty = (count_q != '0);
    assign lu_ready      = (count_q != CntW'(DEPTH));
    assign force_drain   = (starve_cnt_q == StW'(STARVE_MAX)) && fifo_nonempty;
    assign alu_stall     = alu_valid && force_drain;
    assign grant_alu     = alu_valid && !force_drain;
    assign grant_fifo    = !grant_alu && fifo_nonempty;
    assign push          = lu_valid && lu_ready;

    // An entry is live if its distance from the read pointer is below the fill count.
    always_comb begin
        logic [PtrW-1:0] offset;
        logic            hit1, hit2;
        hit1 = rf_we && (rf_waddr == pend_raddr1);
        hit2 = rf_we && (rf_waddr == pend_raddr2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PtrW'(i) - rd_ptr_q;
            if (CntW'(offset) < count_q) begin
                if (fifo_addr_q[i] == pend_raddr1) hit1 = 1'b1;
                if (fifo_addr_q[i] == pend_raddr2) hit2 = 1'b1;
            end
        end
        pend_hit1 = hit1 && (pend_raddr1 != 5'd0);
        pend_hit2 = hit2 && (pend_raddr2 != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= lu_waddr;
            fifo_data_q[wr_ptr_q] <= lu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (grant_fifo) rd_ptr_q <= rd_ptr_q + 1'b1;

            unique case ({push, grant_fifo})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (grant_fifo || !fifo_nonempty) begin
                starve_cnt_q <= '0;
            end else if (grant_alu && (starve_cnt_q != StW'(STARVE_MAX))) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end

            // r0 writes are consumed by the grant but never reach the file.
            if (grant_alu) begin
                rf_we    <= (alu_waddr != 5'd0);
                rf_waddr <= alu_waddr;
                rf_wdata <= alu_wdata;
            end else if (grant_fifo) begin
                rf_we    <= (fifo_addr_q[rd_ptr_q] != 5'd0);
                rf_waddr <= fifo_addr_q[rd_ptr_q];
                rf_wdata <= fifo_data_q[rd_ptr_q];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, STARVE_MAX=4).
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  pend_raddr1;
    logic        pend_hit1;
    logic [4:0]  pend_raddr2;
    logic        pend_hit2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_waddr   (alu_waddr),
        .alu_wdata   (alu_wdata),
        .alu_stall   (alu_stall),
        .lu_valid    (lu_valid),
        .lu_ready    (lu_ready),
        .lu_waddr    (lu_waddr),
        .lu_wdata    (lu_wdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pend_raddr1 (pend_raddr1),
        .pend_hit1   (pend_hit1),
        .pend_raddr2 (pend_raddr2),
        .pend_hit2   (pend_hit2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starvation scenario: value presented each cycle (held while stalled) and expected results.
    logic [31:0] t3_pres [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h104};
    logic        t3_stall[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0]  t3_addr [6] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd9, 5'd10};
    logic [31:0] t3_data [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h99, 32'h104};

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; pend_raddr1 = 5'd7; pend_raddr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_lu_ready", 32'(lu_ready), 32'd1);
        check("rst_stall", 32'(alu_stall), 32'd0);
        check("rst_hit1", 32'(pend_hit1), 32'd0);

        // ALU only
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h12345678;
        tick();
        alu_valid = 1'b0;
        check("alu_we", 32'(rf_we), 32'd1);
        check("alu_waddr", 32'(rf_waddr), 32'd5);
        check("alu_wdata", rf_wdata, 32'h12345678);
        tick();
        check("alu_we_idle", 32'(rf_we), 32'd0);

        // Conflict: r7 queued while ALU writes r3 twice
        alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h33;
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hA5A5A5A5;
        tick();
        lu_valid = 1'b0; alu_wdata = 32'h34; pend_raddr1 = 5'd7; pend_raddr2 = 5'd3;
        #1;
        check("cf_hit1_fifo", 32'(pend_hit1), 32'd1);
        check("cf_hit2_rf", 32'(pend_hit2), 32'd1);
        check("cf_waddr0", 32'(rf_waddr), 32'd3);
        check("cf_wdata0", rf_wdata, 32'h33);
        tick();
        alu_valid = 1'b0;
        check("cf_waddr1", 32'(rf_waddr), 32'd3);
        check("cf_wdata1", rf_wdata, 32'h34);
        #1 check("cf_hit1_wait", 32'(pend_hit1), 32'd1);
        tick();
        check("cf_r7_we", 32'(rf_we), 32'd1);
        check("cf_r7_waddr", 32'(rf_waddr), 32'd7);
        check("cf_r7_wdata", rf_wdata, 32'hA5A5A5A5);
        check("cf_hit1_rf", 32'(pend_hit1), 32'd1);
        tick();
        check("cf_hit1_gone", 32'(pend_hit1), 32'd0);
        check("cf_idle_we", 32'(rf_we), 32'd0);

        // Starvation limit
        lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
        tick();
        lu_valid = 1'b0;
        check("st_no_bypass", 32'(rf_we), 32'd0);
        alu_valid = 1'b1; alu_waddr = 5'd10;
        for (int i = 0; i < 6; i++) begin
            alu_wdata = t3_pres[i];
            #1 check($sformatf("st_stall%0d", i), 32'(alu_stall), 32'(t3_stall[i]));
            tick();
            check($sformatf("st_waddr%0d", i), 32'(rf_waddr), 32'(t3_addr[i]));
            check($sformatf("st_wdata%0d", i), rf_wdata, t3_data[i]);
        end
        alu_valid = 1'b0;
        tick();

        // Full FIFO with ALU saturating the port
        alu_valid = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'h20;
        for (int k = 0; k < 4; k++) begin
            lu_valid = 1'b1; lu_waddr = 5'(11 + k); lu_wdata = 32'hB0 + 32'(k);
            #1 check($sformatf("fl_ready%0d", k), 32'(lu_ready), 32'd1);
            tick();
        end
        lu_waddr = 5'd15; lu_wdata = 32'hB4;
        #1 check("fl_full", 32'(lu_ready), 32'd0);
        check("fl_stall4", 32'(alu_stall), 32'd0);
        tick();
        check("fl_alu4", 32'(rf_waddr), 32'd20);
        #1 check("fl_stall5", 32'(alu_stall), 32'd1);
        check("fl_full_pop", 32'(lu_ready), 32'd0);
        tick();
        check("fl_pop_waddr", 32'(rf_waddr), 32'd11);
        check("fl_pop_wdata", rf_wdata, 32'hB0);
        #1 check("fl_ready_again", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0; alu_valid = 1'b0;
        check("fl_alu6", 32'(rf_waddr), 32'd20);
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("fl_drain_waddr%0d", j), 32'(rf_waddr), 32'(12 + j));
            check($sformatf("fl_drain_wdata%0d", j), rf_wdata, 32'hB1 + 32'(j));
        end
        tick();
        check("fl_empty_we", 32'(rf_we), 32'd0);

        // r0 writes from both sources
        alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hFFFFFFFF;
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hFFFFFFFF;
        tick();
        alu_valid = 1'b0; lu_valid = 1'b0; pend_raddr1 = 5'd0; pend_raddr2 = 5'd0;
        check("r0_alu_we", 32'(rf_we), 32'd0);
        #1 check("r0_hit1", 32'(pend_hit1), 32'd0);
        check("r0_hit2", 32'(pend_hit2), 32'd0);
        tick();
        check("r0_fifo_we", 32'(rf_we), 32'd0);
        tick();
        check("r0_idle_we", 32'(rf_we), 32'd0);

        // Asynchronous reset with entries queued
        alu_valid = 1'b1; alu_waddr = 5'd21; alu_wdata = 32'h21;
        for (int k = 0; k < 3; k++) begin
            lu_valid = 1'b1; lu_waddr = 5'(22 + k); lu_wdata = 32'hC0 + 32'(k);
            tick();
        end
        alu_valid = 1'b0; lu_valid = 1'b0; pend_raddr1 = 5'd22; pend_raddr2 = 5'd21;
        #1 check("rr_hit1_pre", 32'(pend_hit1), 32'd1);
        check("rr_hit2_pre", 32'(pend_hit2), 32'd1);
        check("rr_we_pre", 32'(rf_we), 32'd1);
        #1 reset = 1'b1;
        #1 check("rr_we", 32'(rf_we), 32'd0);
        check("rr_lu_ready", 32'(lu_ready), 32'd1);
        check("rr_hit1", 32'(pend_hit1), 32'd0);
        check("rr_hit2", 32'(pend_hit2), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pend_raddr1 = 5'd23; pend_raddr2 = 5'd24;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_post_we%0d", k), 32'(rf_we), 32'd0);
        end
        check("rr_post_hit1", 32'(pend_hit1), 32'd0);
        check("rr_post_hit2", 32'(pend_hit2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
